// File: rtl/exu_pkg.sv
// Shared constants and types for the EX-stage execute unit.
// Optional RV32M engine is enabled with `define EXU_MULDIV_EN.
package exu_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_e;

endpackage

// File: rtl/exu_muldiv.sv
// Iterative RV32M engine: one bit per cycle shift-add multiply or
// restoring divide on operand magnitudes, sign fixed on the last step.
module exu_muldiv
  import exu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            fin_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d, b_q, b_d;
  logic [2:0] f3_q, f3_d;
  logic an_q, an_d, bn_q, bn_d, bz_q, bz_d;

  logic sa, sb, an, bn, last, dge;
  logic [XLEN:0] msum, dsh, s_acc;
  logic [XLEN-1:0] s_lo, q_s, r_s;
  logic [2*XLEN-1:0] prod, prod_s;

  assign sa = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU)
           || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
  assign sb = (funct3_i == F3_MULH) || (funct3_i == F3_DIV)
           || (funct3_i == F3_REM);
  assign an = sa & a_i[XLEN-1];
  assign bn = sb & b_i[XLEN-1];
  assign last = (cnt_q == CW'(XLEN - 1));

  always_comb begin
    msum = {1'b0, acc_q[XLEN-1:0]} + (lo_q[0] ? {1'b0, b_q} : '0);
    dsh = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    dge = (dsh >= {1'b0, b_q});
    if (f3_q[2]) begin
      s_acc = dge ? dsh - {1'b0, b_q} : dsh;
      s_lo = {lo_q[XLEN-2:0], dge};
    end else begin
      s_acc = {1'b0, msum[XLEN:1]};
      s_lo = {msum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod = {s_acc[XLEN-1:0], s_lo};
    prod_s = (an_q ^ bn_q) ? -prod : prod;
    q_s = (an_q ^ bn_q) ? -s_lo : s_lo;
    r_s = an_q ? -s_acc[XLEN-1:0] : s_acc[XLEN-1:0];
    res_o = '0;
    case (f3_q)
      F3_MUL: res_o = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_o = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: res_o = bz_q ? '1 : q_s;
      default: res_o = r_s;
    endcase
  end

  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    lo_d = lo_q;
    b_d = b_q;
    f3_d = f3_q;
    an_d = an_q;
    bn_d = bn_q;
    bz_d = bz_q;
    unique case (st_q)
      CALC: begin
        acc_d = s_acc;
        lo_d = s_lo;
        cnt_d = cnt_q + 1'b1;
        if (kill_i) st_d = IDLE;
        else if (last) st_d = DONE;
      end
      default: begin
        st_d = IDLE;
        if (start_i) begin
          st_d = CALC;
          cnt_d = '0;
          acc_d = '0;
          lo_d = an ? -a_i : a_i;
          b_d = bn ? -b_i : b_i;
          f3_d = funct3_i;
          an_d = an;
          bn_d = bn;
          bz_d = (b_i == '0);
        end
      end
    endcase
  end

  assign busy_o = (st_q == CALC);
  assign fin_o = (st_q == CALC) & last & ~kill_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      f3_q <= '0;
      an_q <= 1'b0;
      bn_q <= 1'b0;
      bz_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      lo_q <= lo_d;
      b_q <= b_d;
      f3_q <= f3_d;
      an_q <= an_d;
      bn_q <= bn_d;
      bz_q <= bz_d;
    end
  end

endmodule

// File: rtl/exu_pipe.sv
// EX stage: ALU, branch/jump resolution with registered redirect.
// `define EXU_MULDIV_EN adds the iterative RV32M engine.
module exu_pipe
  import exu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            kill,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            is_muldiv,
  input  logic            alu_src1,
  input  logic            alu_src2,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            reg_wr,
  output logic            pc_src,
  output logic [XLEN-1:0] target,
  output logic            flush,
  output logic            illegal
);

  logic acc, md_busy, md_fin, take, bad;
  logic [XLEN-1:0] md_res, a, b, alu;
  logic [SHAMT_W-1:0] sh;

  logic vld_q, vld_d, wr_q, wr_d, pcs_q, pcs_d, ill_q, ill_d;
  logic [XLEN-1:0] res_q, res_d, tgt_q, tgt_d;

  assign in_ready = ~md_busy;
  assign acc = in_valid & in_ready & ~kill;

`ifdef EXU_MULDIV_EN
  exu_muldiv #(.XLEN(XLEN)) u_md (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (acc & is_muldiv),
    .kill_i  (kill),
    .funct3_i(funct3),
    .a_i     (rs1_data),
    .b_i     (rs2_data),
    .busy_o  (md_busy),
    .fin_o   (md_fin),
    .res_o   (md_res)
  );
`else
  assign md_busy = 1'b0;
  assign md_fin = 1'b0;
  assign md_res = '0;
`endif

  assign a = alu_src1 ? pc : rs1_data;
  assign b = alu_src2 ? imm : rs2_data;
  assign sh = b[SHAMT_W-1:0];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_XOR:  alu = a ^ b;
      ALU_OR:   alu = a | b;
      ALU_AND:  alu = a & b;
      ALU_SLL:  alu = a << sh;
      ALU_SRL:  alu = a >> sh;
      ALU_SRA:  alu = $signed(a) >>> sh;
      ALU_SLT:  alu = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: alu = XLEN'(a < b);
      default:  alu = '0;
    endcase
  end

  // Branch compare always uses the register operands, never the muxed ones.
  always_comb begin
    take = 1'b0;
    bad = 1'b0;
    case (funct3)
      F3_BEQ:  take = (rs1_data == rs2_data);
      F3_BNE:  take = (rs1_data != rs2_data);
      F3_BLT:  take = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  take = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: take = (rs1_data < rs2_data);
      F3_BGEU: take = (rs1_data >= rs2_data);
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    vld_d = 1'b0;
    res_d = res_q;
    wr_d = 1'b0;
    pcs_d = 1'b0;
    tgt_d = tgt_q;
    ill_d = 1'b0;
    if (md_fin) begin
      vld_d = 1'b1;
      res_d = md_res;
      wr_d = 1'b1;
    end else if (acc && is_muldiv) begin
`ifndef EXU_MULDIV_EN
      vld_d = 1'b1;
      res_d = '0;
      ill_d = 1'b1;
`endif
    end else if (acc) begin
      vld_d = 1'b1;
      res_d = alu;
      wr_d = 1'b1;
      unique case (1'b1)
        opcode == OP_BRANCH: begin
          wr_d = 1'b0;
          pcs_d = take;
          ill_d = bad;
          tgt_d = pc + imm;
        end
        opcode == OP_JAL: begin
          pcs_d = 1'b1;
          res_d = pc + XLEN'(4);
          tgt_d = pc + imm;
        end
        opcode == OP_JALR: begin
          pcs_d = 1'b1;
          res_d = pc + XLEN'(4);
          tgt_d = (rs1_data + imm) & ~XLEN'(1);
        end
        opcode == OP_STORE: wr_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= 1'b0;
      res_q <= '0;
      wr_q <= 1'b0;
      pcs_q <= 1'b0;
      tgt_q <= '0;
      ill_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      wr_q <= wr_d;
      pcs_q <= pcs_d;
      tgt_q <= tgt_d;
      ill_q <= ill_d;
    end
  end

  // A late kill squashes a result that is already sitting in the outputs.
  assign out_valid = vld_q & ~kill;
  assign result = res_q;
  assign target = tgt_q;
  assign reg_wr = wr_q & out_valid;
  assign pc_src = pcs_q & out_valid;
  assign flush = pc_src;
  assign illegal = ill_q & out_valid;

endmodule

// File: tb/tb_exu_pipe.sv
// Self-checking bench for exu_pipe: directed table, random ALU/branch
// traffic against a reference model, and multi-cycle M-op sequences.
module tb_exu_pipe;

  logic CLK = 1'b0, RST = 1'b1;
  logic in_valid = 0, in_ready, kill = 0;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic is_muldiv = 0, alu_src1 = 0, alu_src2 = 0;
  logic [3:0] alu_op = 0;
  logic [31:0] rs1_data = 0, rs2_data = 0, imm = 0, pc = 0;
  logic out_valid, reg_wr, pc_src, flush, illegal;
  logic [31:0] result, target;

  int n_vec = 0, n_err = 0;

  exu_pipe #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .kill(kill), .opcode(opcode), .funct3(funct3), .is_muldiv(is_muldiv),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .result(result), .reg_wr(reg_wr),
    .pc_src(pc_src), .target(target), .flush(flush), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] BR = 7'b1100011, ST = 7'b0100011;
  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011;
  localparam logic [6:0] AUI = 7'b0010111;

  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic s1, s2; logic [3:0] aop;
    logic [31:0] r1, r2, im, p;
    logic chkr; logic [31:0] res; logic wr, pcs;
    logic chkt; logic [31:0] tgt; logic ill;
  } vec_t;

  typedef struct {
    logic chkr; logic [31:0] res; logic wr, pcs;
    logic chkt; logic [31:0] tgt; logic ill;
  } exp_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic [6:0] o, input logic [2:0] f,
                         input logic x1, x2, input logic [3:0] op,
                         input logic [31:0] r1, r2, im_, p_,
                         input logic md);
    opcode = o; funct3 = f; alu_src1 = x1; alu_src2 = x2; alu_op = op;
    rs1_data = r1; rs2_data = r2; imm = im_; pc = p_; is_muldiv = md;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] x, y);
    int sx, sy;
    logic [4:0] s;
    sx = x; sy = y; s = y[4:0];
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x ^ y;
      3: return x | y;
      4: return x & y;
      5: return x << s;
      6: return x >> s;
      7: return 32'(sx >>> s);
      8: return (sx < sy) ? 32'd1 : 32'd0;
      9: return (x < y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f,
                                 input logic x1, x2, input logic [3:0] op,
                                 input logic [31:0] r1, r2, im_, p_);
    exp_t e;
    int s1, s2;
    bit tk;
    s1 = r1; s2 = r2;
    e = '{1, alu_ref(op, x1 ? p_ : r1, x2 ? im_ : r2), 1, 0, 0, 0, 0};
    if (o == BR) begin
      case (f)
        0: tk = (r1 == r2);
        1: tk = (r1 != r2);
        4: tk = (s1 < s2);
        5: tk = !(s1 < s2);
        6: tk = (r1 < r2);
        7: tk = !(r1 < r2);
        default: tk = 0;
      endcase
      e.chkr = 0; e.wr = 0; e.pcs = tk; e.chkt = 1; e.tgt = p_ + im_;
      e.ill = (f == 2 || f == 3);
    end else if (o == JAL || o == JALR) begin
      e.res = p_ + 4; e.pcs = 1; e.chkt = 1;
      e.tgt = (o == JAL) ? p_ + im_ : (r1 + im_) & 32'hFFFF_FFFE;
    end else if (o == ST) begin
      e.chkr = 0; e.wr = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] md_ref(input logic [2:0] f,
                                         input logic [31:0] x, y);
    logic [63:0] xe, ye, p;
    int sx, sy;
    bit ovf;
    sx = x; sy = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    xe = (f == 1 || f == 2) ? {{32{x[31]}}, x} : {32'b0, x};
    ye = (f == 1) ? {{32{y[31]}}, y} : {32'b0, y};
    p = xe * ye;
    case (f)
      0: return p[31:0];
      1, 2, 3: return p[63:32];
      4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(sx / sy);
      5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      6: return (y == 0) ? x : ovf ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk_out(input string nm, input exp_t e);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    if (e.chkr) chk({nm, ".result"}, result, e.res);
    chk({nm, ".reg_wr"}, 32'(reg_wr), 32'(e.wr));
    chk({nm, ".pc_src"}, 32'(pc_src), 32'(e.pcs));
    chk({nm, ".flush"}, 32'(flush), 32'(e.pcs));
    if (e.chkt) chk({nm, ".target"}, target, e.tgt);
    chk({nm, ".illegal"}, 32'(illegal), 32'(e.ill));
  endtask

  // Issue one M op and watch it to completion; returns observed latency.
  task automatic run_md(input string nm, input logic [2:0] f,
                        input logic [31:0] x, y, input logic [31:0] exp);
    int lat;
    bit rdy_hi;
    lat = 0; rdy_hi = 0;
    @(negedge CLK);
    set_req(OPR, f, 0, 0, 0, x, y, 0, 0, 1); in_valid = 1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge CLK);
      in_valid = 0; is_muldiv = 0;
      if (out_valid) lat = c;
      else if (in_ready) rdy_hi = 1;
    end
    chk({nm, ".latency"}, 32'(lat), 32'd33);
    chk({nm, ".ready_in_calc"}, 32'(rdy_hi), 32'd0);
    chk({nm, ".result"}, result, exp);
    chk({nm, ".reg_wr"}, 32'(reg_wr), 32'd1);
  endtask

  initial begin
    exp_t e, pend;
    bit have;
    int seen;
    logic [2:0] f;
    logic [31:0] x, y;

    vt.push_back('{OPI, 0, 0, 1, 0, 5, 0, 32'hFFFF_FFFD, 0, 1, 2, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 1, 10, 3, 0, 0, 1, 7, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 2, 32'hF0F0, 32'h0FF0, 0, 0, 1, 32'hFF00, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 5, 1, 32'h24, 0, 0, 1, 16, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 7, 32'h8000_0000, 4, 0, 0, 1, 32'hF800_0000, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 6, 32'h8000_0000, 4, 0, 0, 1, 32'h0800_0000, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 8, 32'hFFFF_FFFF, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0});
    vt.push_back('{OPR, 0, 0, 0, 9, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0});
    vt.push_back('{AUI, 0, 1, 1, 0, 0, 0, 32'h1000, 32'h100, 1, 32'h1100, 1, 0, 0, 0, 0});
    vt.push_back('{BR, 6, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h400, 0, 0, 0, 0, 1, 32'h420, 0});
    vt.push_back('{BR, 4, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h20, 32'h400, 0, 0, 0, 1, 1, 32'h420, 0});
    vt.push_back('{BR, 5, 0, 0, 0, 7, 7, 32'hFFFF_FFF0, 32'h400, 0, 0, 0, 1, 1, 32'h3F0, 0});
    vt.push_back('{BR, 7, 0, 0, 0, 7, 7, 8, 32'h80, 0, 0, 0, 1, 1, 32'h88, 0});
    vt.push_back('{BR, 1, 0, 0, 0, 7, 7, 8, 32'h80, 0, 0, 0, 0, 1, 32'h88, 0});
    vt.push_back('{BR, 2, 0, 0, 0, 1, 2, 8, 32'h80, 0, 0, 0, 0, 1, 32'h88, 1});
    vt.push_back('{JALR, 0, 0, 1, 0, 32'h1001, 0, 4, 32'h200, 1, 32'h204, 1, 1, 1, 32'h1004, 0});
    vt.push_back('{JAL, 0, 1, 1, 0, 0, 0, 32'h40, 32'h300, 1, 32'h304, 1, 1, 1, 32'h340, 0});
    vt.push_back('{ST, 2, 0, 1, 0, 32'h100, 9, 8, 0, 0, 0, 0, 0, 0, 0, 0});

    #1;
    chk("reset.valid", 32'(out_valid), 0);
    chk("reset.ready", 32'(in_ready), 1);
    chk("reset.result", result, 0);
    chk("reset.target", target, 0);
    chk("reset.pc_src", 32'(pc_src | flush | reg_wr), 0);
    repeat (2) @(negedge CLK);
    RST = 0;

    foreach (vt[i]) begin
      @(negedge CLK);
      set_req(vt[i].opc, vt[i].f3, vt[i].s1, vt[i].s2, vt[i].aop,
              vt[i].r1, vt[i].r2, vt[i].im, vt[i].p, 0);
      in_valid = 1;
      @(negedge CLK);
      in_valid = 0;
      e = '{vt[i].chkr, vt[i].res, vt[i].wr, vt[i].pcs,
            vt[i].chkt, vt[i].tgt, vt[i].ill};
      chk_out($sformatf("tbl%0d", i), e);
      @(negedge CLK);
      chk($sformatf("tbl%0d.after", i), 32'(out_valid | flush), 0);
    end

    have = 0;
    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      logic [31:0] r1, r2;
      @(negedge CLK);
      if (have) chk_out($sformatf("rnd%0d", i), pend);
      else chk($sformatf("rnd%0d.idle", i), 32'(out_valid), 0);
      case ($urandom_range(0, 6))
        0: o = OPR; 1: o = OPI; 2: o = AUI; 3, 4: o = BR;
        5: o = JAL; default: o = ($urandom_range(0, 1) != 0) ? JALR : ST;
      endcase
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      set_req(o, 3'($urandom), 1'($urandom), 1'($urandom),
              4'($urandom_range(0, 9)), r1, r2, $urandom, $urandom, 0);
      in_valid = ($urandom_range(0, 3) != 0);
      have = in_valid;
      pend = model(opcode, funct3, alu_src1, alu_src2, alu_op,
                   rs1_data, rs2_data, imm, pc);
    end
    @(negedge CLK);
    in_valid = 0;
    if (have) chk_out("rnd.last", pend);

    @(negedge CLK);
    set_req(OPI, 0, 0, 1, 0, 1, 0, 1, 0, 0); in_valid = 1; kill = 1;
    @(negedge CLK);
    in_valid = 0; kill = 0;
    chk("kill_accept.valid", 32'(out_valid), 0);
    set_req(OPI, 0, 0, 1, 0, 1, 0, 1, 0, 0); in_valid = 1;
    @(negedge CLK);
    in_valid = 0; kill = 1; #1;
    chk("kill_pending.valid", 32'(out_valid), 0);
    chk("kill_pending.reg_wr", 32'(reg_wr), 0);
    @(negedge CLK);
    kill = 0;

`ifdef EXU_MULDIV_EN
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    run_md("divu_0", 3'd5, 10, 0, 32'hFFFF_FFFF);
    run_md("div_0", 3'd4, 32'hFFFF_FFF6, 0, 32'hFFFF_FFFF);
    run_md("rem_0", 3'd6, 32'hFFFF_FFF6, 0, 32'hFFFF_FFF6);
    run_md("mulh", 3'd1, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFF);
    run_md("mul", 3'd0, 32'hFFFF_FFFE, 3, 32'hFFFF_FFFA);
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom);
      x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: y = 0; 1: y = 32'hFFFF_FFFF; 2: y = $urandom_range(1, 20);
        default: y = $urandom;
      endcase
      run_md($sformatf("md%0d_f%0d", i, f), f, x, y, md_ref(f, x, y));
    end

    @(negedge CLK);
    set_req(OPR, 3'd4, 0, 0, 0, 100, 7, 0, 0, 1); in_valid = 1;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      in_valid = 0; is_muldiv = 0;
      if (out_valid) seen++;
    end
    kill = 1;
    @(negedge CLK);
    kill = 0;
    chk("kill_calc.ready", 32'(in_ready), 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    chk("kill_calc.no_valid", 32'(seen), 0);

    @(negedge CLK);
    set_req(JAL, 0, 1, 1, 0, 0, 0, 32'h40, 32'h300, 0); in_valid = 1;
    @(negedge CLK);
    set_req(OPR, 3'd0, 0, 0, 0, 6, 7, 0, 0, 1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      in_valid = 0; is_muldiv = 0;
    end
    RST = 1; #1;
    chk("rst_calc.valid", 32'(out_valid), 0);
    chk("rst_calc.result", result, 0);
    chk("rst_calc.target", target, 0);
    chk("rst_calc.ready", 32'(in_ready), 1);
    @(negedge CLK);
    RST = 0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (out_valid) seen++;
    end
    chk("rst_calc.no_valid", 32'(seen), 0);
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      set_req(OPR, 3'(i * 2), 0, 0, 0, 32'h1234, 5, 0, 0, 1); in_valid = 1;
      @(negedge CLK);
      in_valid = 0; is_muldiv = 0;
      e = '{1, 0, 0, 0, 0, 0, 1};
      chk_out($sformatf("nomd%0d", i), e);
      chk($sformatf("nomd%0d.ready", i), 32'(in_ready), 1);
    end
    @(negedge CLK);
    set_req(JAL, 0, 1, 1, 0, 0, 0, 32'h40, 32'h300, 0); in_valid = 1;
    @(negedge CLK);
    in_valid = 0;
    RST = 1; #1;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.result", result, 0);
    chk("rst.target", target, 0);
    chk("rst.ready", 32'(in_ready), 1);
    @(negedge CLK);
    RST = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exu_pipe.md
Name: exu_pipe

Overview:
- Parametrised successor to the five-stage CPU's single-cycle ALU/branch comparator.
- Sits in the EX stage.
- Executes RV32I ALU ops, resolves branches and jumps with a registered redirect, and adds an iterative RV32M multiply/divide engine.
- Uses a valid/ready handshake so multi-cycle ops stall the front end.

Parameters:
XLEN, 32, datapath width; must be 32 or 64
SHAMT_W, $clog2(XLEN), shift-amount bits taken from operand B

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
in_valid  in  1  EX request present
in_ready  out  1  unit can accept a request this cycle
kill  in  1  abort in-flight request (younger-instruction squash)
opcode  in  7  instruction opcode
funct3  in  3  branch type / M-op select
is_muldiv  in  1  request is an RV32M op
alu_src1  in  1  0: rs1_data, 1: pc
alu_src2  in  1  0: rs2_data, 1: imm
alu_op  in  4  ALU function
rs1_data  in  XLEN  source 1
rs2_data  in  XLEN  source 2
imm  in  XLEN  sign-extended immediate
pc  in  XLEN  instruction address
out_valid  out  1  one-cycle pulse, result fields valid
result  out  XLEN  ALU/M result; pc+4 for JAL/JALR
reg_wr  out  1  result writes rd
pc_src  out  1  redirect taken
target  out  XLEN  redirect address
flush  out  1  squash IF/ID, same cycle as pc_src
illegal  out  1  unsupported request

Behaviour:
- Reset values (immediate, asynchronous): out_valid, reg_wr, pc_src and flush are 0; result and target are 0; in_ready is 1; FSM is IDLE.
- Accept: in_valid & in_ready at a rising edge.
- Single-cycle ops: out_valid is high in the cycle after accept. All outputs are registered. Back-to-back accepts are allowed.
- alu_op encodings: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- Shifts use B[SHAMT_W-1:0] only. SLT and SLTU return 0 or 1.
- Branch (1100011):
  - Comparison is always rs1_data vs rs2_data.
  - BEQ/BNE test equality. BLT/BGE are signed. BLTU/BGEU are unsigned.
  - BGE and BGEU are taken on equality.
  - target = pc + imm. reg_wr = 0. funct3 010/011 sets illegal.
- JAL (1101111): target = pc + imm, pc_src = 1, result = pc + 4, reg_wr = 1.
- JALR (1100111): target = (rs1_data + imm) & ~1, pc_src = 1, result = pc + 4, reg_wr = 1.
- Store (0100011): reg_wr = 0, pc_src = 0.
- All other opcodes: reg_wr = 1.
- flush equals pc_src and is valid only while out_valid.
- pc_src, flush and reg_wr are 0 whenever out_valid is 0.
- M-op FSM (is_muldiv accepted):
  - States: IDLE -> CALC (XLEN cycles, one bit per cycle, shift-add or restoring division) -> DONE (1 cycle, out_valid = 1) -> IDLE.
  - in_ready is 0 in CALC and 1 in DONE, so a new request may be accepted in the DONE cycle.
  - Accept at edge 0 gives out_valid in cycle XLEN+1.
  - MUL returns the low word. MULH, MULHSU and MULHU return the high word with the correct operand signedness.
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend. Completes with normal latency.
  - Overflow (DIV of most-negative by -1): quotient = dividend; REM = 0.
- kill:
  - In CALC: the FSM returns to IDLE next cycle, no out_valid, in_ready = 1.
  - In the same cycle as accept: the request is dropped.
  - With a single-cycle result pending: out_valid is suppressed.
- RST mid-CALC: the operation is discarded and all outputs return to reset values.
- in_valid with in_ready = 0: ignored; upstream holds the request.

Optional Feature:
EXU_MULDIV_EN
- Defined: exu_muldiv is instantiated and behaves as above.
- Undefined: no M engine.
  - An is_muldiv request completes in 1 cycle with result = 0, reg_wr = 0, illegal = 1.
  - in_ready stays constantly 1.

Decomposition:
- Package exu_pkg holds:
  - Opcode constants: OP_BRANCH, OP_STORE, OP_JAL, OP_JALR.
  - alu_op encodings and branch funct3 codes (BEQ..BGEU).
  - M funct3 codes (MUL..REMU).
  - FSM state typedef {IDLE, CALC, DONE}.
- One sub-module: exu_muldiv, the iterative engine with its own start/done/kill.
- exu_pipe holds the ALU, branch logic and output registers.

Test Plan:
- ADD: rs1 = 5, imm = -3, alu_src2 = 1 -> next cycle out_valid = 1, result = 2, reg_wr = 1, pc_src = 0.
- BLTU: rs1 = 0xFFFFFFFF, rs2 = 1 -> not taken. BLT with the same operands -> taken, target = pc + imm, flush = 1 for exactly 1 cycle.
- BGE with equal operands 7, 7 -> pc_src = 1.
- JALR: rs1 = 0x1001, imm = 4, pc = 0x200 -> target = 0x1004, result = 0x204.
- DIV: 0x80000000 by 0xFFFFFFFF -> out_valid at cycle 33, result = 0x80000000, in_ready low for cycles 1-32. DIVU 10/0 -> 0xFFFFFFFF.
- MULH: -2 * 3 -> 0xFFFFFFFF.
- kill asserted at CALC cycle 10 -> no out_valid, in_ready = 1 next cycle.
- RST asserted mid-CALC -> all outputs are 0 immediately and in_ready = 1.
